// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract unit: WIDTH bits split into STAGES slices,
// each slice built from GROUP-bit lookahead groups, with valid/ready flow control.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / GROUP;
  localparam int LAST  = STAGES - 1;

  // Returns {carry_out, sum}; every internal carry is expanded from the group carry-in.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             cin);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   gx;
    logic [GROUP:0]   c;
    logic             term;
    p  = a ^ b;
    g  = a & b;
    gx = {g, cin};
    c  = '0;
    c[0] = cin;
    for (int j = 0; j < GROUP; j++) begin
      for (int m = 0; m <= j + 1; m++) begin
        term = gx[m];
        for (int n = m; n <= j; n++) term = term & p[n];
        c[j+1] = c[j+1] | term;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    logic [SLICE-1:0] s;
    logic             c;
    logic [GROUP:0]   r;
    s = '0;
    c = cin;
    for (int q = 0; q < NGRP; q++) begin
      r = cla_group(a[q*GROUP +: GROUP], b[q*GROUP +: GROUP], c);
      s[q*GROUP +: GROUP] = r[GROUP-1:0];
      c = r[GROUP];
    end
    return {c, s};
  endfunction

  // opa starts as operand A; each stage overwrites its slice with finished sum bits.
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  opa     [STAGES];
  logic [WIDTH-1:0]  opb     [STAGES];
  logic              cy      [STAGES];
  logic [WIDTH-1:0]  nxt_opa [STAGES];
  logic [SLICE:0]    nxt_res [STAGES];
  logic              advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_res[k] = cla_slice(opa[k][k*SLICE +: SLICE], opb[k][k*SLICE +: SLICE], cy[k]);
      nxt_opa[k] = opa[k];
      nxt_opa[k][k*SLICE +: SLICE] = nxt_res[k][SLICE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        opa[k] <= '0;
        opb[k] <= '0;
        cy[k]  <= 1'b0;
      end
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
    end else if (advance) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        opa[0] <= A;
        opb[0] <= Sub ? ~B : B;
        cy[0]  <= Sub ^ Cin;
      end
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          opa[k] <= nxt_opa[k-1];
          opb[k] <= opb[k-1];
          cy[k]  <= nxt_res[k-1][SLICE];
        end
      end
      out_valid <= vld[LAST];
      if (vld[LAST]) begin
        Sum  <= nxt_opa[LAST];
        Cout <= nxt_res[LAST][SLICE];
        // carry into the MSB is recovered as P[msb] ^ Sum[msb]
        Ovf  <= nxt_res[LAST][SLICE] ^ opa[LAST][WIDTH-1] ^ opb[LAST][WIDTH-1]
                ^ nxt_opa[LAST][WIDTH-1];
        Zero <= (nxt_opa[LAST] == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases on the default build plus a randomized
// scoreboard run across four STAGES/GROUP builds.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  localparam int NI = 4;
  localparam int STG [NI] = '{2, 1, 4, 8};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic        in_ready_v  [NI];
  logic        out_valid_v [NI];
  logic [31:0] sum_v       [NI];
  logic        cout_v      [NI];
  logic        ovf_v       [NI];
  logic        zero_v      [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .Sum(sum_v[0]), .Cout(cout_v[0]), .Ovf(ovf_v[0]), .Zero(zero_v[0]));
  cla_pipe_adder #(.WIDTH(32), .GROUP(8), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .Sum(sum_v[1]), .Cout(cout_v[1]), .Ovf(ovf_v[1]), .Zero(zero_v[1]));
  cla_pipe_adder #(.WIDTH(32), .GROUP(8), .STAGES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .Sum(sum_v[2]), .Cout(cout_v[2]), .Ovf(ovf_v[2]), .Zero(zero_v[2]));
  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .Sum(sum_v[3]), .Cout(cout_v[3]), .Ovf(ovf_v[3]), .Zero(zero_v[3]));

  // Reference: exact integer arithmetic; overflow means the wrapped result differs
  // from the true signed result.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    res_t        r;
    logic [32:0] u;
    longint      sx, sy, sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      u = {1'b0, x} + {1'b0, y} + {32'd0, c};
      r.cout = u[32];
      sr = sx + sy + longint'(c);
    end else begin
      u = {1'b0, x} - {1'b0, y} - {32'd0, c};
      r.cout = !u[32];
      sr = sx - sy - longint'(c);
    end
    r.sum  = u[31:0];
    r.ovf  = (sr != longint'($signed(u[31:0])));
    r.zero = (u[31:0] == 32'd0);
    return r;
  endfunction

  function automatic res_t observed(input int i);
    return {sum_v[i], cout_v[i], ovf_v[i], zero_v[i]};
  endfunction

  // Drives one op into dut0 and waits (bounded) for its result; lat=-1 on timeout.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                        input logic s, output res_t r, output int lat);
    @(posedge clk); #1;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = -1;
    r = '0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_valid_v[0]) begin
        lat = j;
        r = observed(0);
        break;
      end
    end
  endtask

  task automatic test_reset;
    res_t r;
    int   lat;
    rst_n = 1'b0; in_valid = 1'b1; a = $urandom; b = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid_v[0] !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_v[0]); end
    checks++; if (sum_v[0] !== 32'd0) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum_v[0]); end
    checks++; if (cout_v[0] !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout_v[0]); end
    checks++; if (ovf_v[0] !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_v[0]); end
    checks++; if (zero_v[0] !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero_v[0]); end
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b1;
    run_op(32'd1, 32'd2, 1'b0, 1'b0, r, lat);
    checks++; if (lat !== STG[0]) begin failures++; $display("FAIL first_latency got=%0d exp=%0d", lat, STG[0]); end
    checks++; if (r.sum !== 32'd3) begin failures++; $display("FAIL first_sum got=%h exp=3", r.sum); end
    checks++; if (r.cout !== 1'b0 || r.zero !== 1'b0) begin failures++; $display("FAIL first_flags got cout=%b zero=%b exp 0 0", r.cout, r.zero); end
  endtask

  task automatic test_carry;
    res_t r;
    int   lat;
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, r, lat);
    checks++; if (lat !== STG[0]) begin failures++; $display("FAIL carry_mid_latency got=%0d exp=%0d", lat, STG[0]); end
    checks++; if ({r.sum, r.cout} !== {32'h00010000, 1'b0}) begin failures++; $display("FAIL carry_mid got=%h/%b exp=00010000/0", r.sum, r.cout); end
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, r, lat);
    checks++; if (r !== res_t'({32'h0, 1'b1, 1'b0, 1'b1})) begin failures++; $display("FAIL carry_full got sum=%h cout=%b ovf=%b zero=%b exp 0 1 0 1", r.sum, r.cout, r.ovf, r.zero); end
  endtask

  task automatic test_overflow;
    res_t r;
    int   lat;
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, r, lat);
    checks++; if (r !== res_t'({32'h80000000, 1'b0, 1'b1, 1'b0})) begin failures++; $display("FAIL ovf_add got sum=%h cout=%b ovf=%b zero=%b exp 80000000 0 1 0", r.sum, r.cout, r.ovf, r.zero); end
    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, r, lat);
    checks++; if (r !== res_t'({32'h7FFFFFFF, 1'b1, 1'b1, 1'b0})) begin failures++; $display("FAIL ovf_sub got sum=%h cout=%b ovf=%b zero=%b exp 7fffffff 1 1 0", r.sum, r.cout, r.ovf, r.zero); end
  endtask

  task automatic test_subtract;
    res_t r;
    int   lat;
    run_op(32'd5, 32'd7, 1'b1, 1'b1, r, lat);
    checks++; if ({r.sum, r.cout} !== {32'hFFFFFFFD, 1'b0}) begin failures++; $display("FAIL sub_borrow got=%h/%b exp=fffffffd/0", r.sum, r.cout); end
    run_op(32'd7, 32'd5, 1'b0, 1'b1, r, lat);
    checks++; if ({r.sum, r.cout} !== {32'd2, 1'b1}) begin failures++; $display("FAIL sub_plain got=%h/%b exp=00000002/1", r.sum, r.cout); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ea [4];
    logic [31:0] eb [4];
    logic        ec [4];
    logic        es [4];
    res_t        exp_r [4];
    res_t        got [$];
    res_t        r;
    for (int i = 0; i < 4; i++) begin
      ea[i] = $urandom; eb[i] = $urandom; ec[i] = 1'($urandom); es[i] = (i % 2) == 1;
      exp_r[i] = model(ea[i], eb[i], ec[i], es[i]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a = ea[i]; b = eb[i]; cin = ec[i]; sub = es[i]; in_valid = 1'b1;
    end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++; if (in_ready_v[0] !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", s, in_ready_v[0]); end
      checks++; if (out_valid_v[0] !== 1'b1 || sum_v[0] !== exp_r[0].sum) begin failures++; $display("FAIL stall_hold cyc=%0d got valid=%b sum=%h exp 1 %h", s, out_valid_v[0], sum_v[0], exp_r[0].sum); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid_v[0]) begin
        r = observed(0);
        got.push_back(r);
      end
      @(posedge clk); #1;
      if (c == 0) in_valid = 1'b0;
    end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_r[i]) begin failures++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, got[i], exp_r[i]); end
    end
  endtask

  task automatic test_random;
    res_t sb [NI][64];
    int   wp [NI];
    int   rp [NI];
    res_t r;
    logic [31:0] specials [6];
    specials[0] = 32'h0; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h7FFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h00000001; specials[5] = 32'h0000FFFF;
    for (int i = 0; i < NI; i++) begin wp[i] = 0; rp[i] = 0; end
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          wp[i] = 0; rp[i] = 0;
          checks++; if (out_valid_v[i] !== 1'b0) begin failures++; $display("FAIL rand_reset_valid dut=%0d got=%b exp=0", i, out_valid_v[i]); end
        end else begin
          if (out_valid_v[i] && out_ready) begin
            r = observed(i);
            checks++;
            if (rp[i] == wp[i]) begin failures++; $display("FAIL rand_spurious dut=%0d got=%h exp=none", i, r); end
            else begin
              if (r !== sb[i][rp[i] % 64]) begin failures++; $display("FAIL rand_result dut=%0d got=%h exp=%h", i, r, sb[i][rp[i] % 64]); end
              rp[i]++;
            end
          end
          if (in_valid && in_ready_v[i]) begin
            sb[i][wp[i] % 64] = model(a, b, cin, sub);
            wp[i]++;
          end
        end
      end
      @(posedge clk); #1;
      if (cyc == 300) rst_n = 1'b0;
      if (cyc == 303) rst_n = 1'b1;
      if (cyc < 650) begin
        in_valid  = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 3) != 0;
        a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
        b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++; if (wp[i] != rp[i]) begin failures++; $display("FAIL rand_drain dut=%0d outstanding=%0d exp=0", i, wp[i] - rp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead add/subtract unit built from GROUP-bit lookahead groups. The WIDTH-bit operation is split into STAGES slices, one per pipeline stage, with the slice carry registered between stages. A valid/ready handshake on both sides allows back-pressure. It serves as the ALU adder for the RV32I datapath and for address generation.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of GROUP*STAGES
GROUP, 4, bits per carry-lookahead group (generate/propagate block)
STAGES, 2, pipeline stages = latency in cycles; 1..WIDTH/GROUP

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/mode valid this cycle
in_ready  out  1  unit accepts input this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
Cin  in  1  carry-in (add) / borrow-in (sub)
Sub  in  1  0: A+B+Cin; 1: A-B-Cin
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
Sum  out  WIDTH  result
Cout  out  1  carry-out (add) / NOT borrow-out (sub)
Ovf  out  1  signed two's-complement overflow
Zero  out  1  Sum == 0

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): all stage valid bits 0; out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0. All pipeline data registers clear to 0.
- Operand prep: Beff = Sub ? ~B : B; c0 = Sub ? ~Cin : Cin. Add: A+B+Cin. Sub: A+~B+~Cin = A-B-Cin.
- Per bit: P=A^Beff, G=A&Beff. Within a group, carries are full lookahead from the group carry-in, i.e. c[i+1] expanded in terms of G/P and the group carry-in with no ripple through c[i]. Group carry-outs inside a slice ripple group-to-group; Sum[i]=P[i]^c[i].
- Slice k (width WIDTH/STAGES) is computed in stage k from the registered carry of stage k-1 (stage 0 uses c0). Unprocessed high operand bits and completed low Sum bits travel with the stage registers (skew/deskew). Last stage registers Sum/Cout/Ovf/Zero directly onto the outputs.
- Cout = carry out of bit WIDTH-1. Ovf = carry into MSB XOR carry out of MSB. Zero computed on the full final Sum in the last stage.
- Latency: exactly STAGES cycles from accepted input (in_valid&&in_ready at edge N) to out_valid at edge N+STAGES, with no stalls.
- Handshake: advance = !out_valid || out_ready; in_ready = advance (global stall). When advance=0 every stage register holds its value, and outputs stay stable while out_valid&&!out_ready. A stage receiving no accepted input loads valid=0 when advancing.
- Throughput 1 result/cycle when out_ready held high; back-to-back ops with differing Sub do not interfere (Sub carried per stage).
- Simultaneous out_ready drop and new in_valid: input not accepted (in_ready=0); no loss or duplication.
- rst_n asserted mid-operation: all in-flight ops discarded immediately; no out_valid after release until a new accepted input plus STAGES cycles.
- Inputs are sampled only on accepted cycles; A/B/Cin/Sub are don't-care otherwise.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0; release, present A=1,B=2,Cin=0,Sub=0 -> 2 cycles later Sum=3, Cout=0, Zero=0.
- Carry across stage boundary: A=0x0000FFFF, B=0x00000001, Cin=0 -> Sum=0x00010000, Cout=0; A=0xFFFFFFFF, B=1 -> Sum=0, Cout=1, Zero=1, Ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=1, add -> Sum=0x80000000, Ovf=1, Cout=0; A=0x80000000, B=1, Sub=1, Cin=0 -> Sum=0x7FFFFFFF, Ovf=1, Cout=1.
- Subtract with borrow: A=5, B=7, Sub=1, Cin=1 -> Sum=0xFFFFFFFD, Cout=0; A=7, B=5, Sub=1, Cin=0 -> Sum=2, Cout=1.
- Back-pressure: stream 4 back-to-back ops, drop out_ready for 3 cycles after the first result -> in_ready=0 during the stall, outputs held stable, all 4 results delivered in order with no duplicates.
- Random regression with STAGES=1,2,4,8 and GROUP=4,8 against a reference model; reset asserted mid-stream -> no stale result emitted after release.
